// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit path and its arbiter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream request bundle between the message sources and the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  import uart_pkg::*;

  logic [N_REQ-1:0]                  req_valid;
  logic [N_REQ-1:0][UART_DATA_W-1:0] req_data;
  logic [N_REQ-1:0]                  req_last;
  logic [N_REQ-1:0]                  req_ready;

  modport master (output req_valid, req_data, req_last, input req_ready);
  modport slave  (input req_valid, req_data, req_last, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker with an optional lock that pins the grant to one requester.
module rr_arbiter import uart_pkg::*; #(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            lock,
  input  logic [ID_W-1:0] lock_id,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    gnt_valid  = 1'b0;
    idx        = '0;
    if (lock) begin
      if (req[lock_id]) begin
        gnt_onehot[lock_id] = 1'b1;
        gnt_id              = lock_id;
        gnt_valid           = 1'b1;
      end
    end else begin
      // Walk downward so the requester nearest ptr is the last writer and wins.
      for (int i = N - 1; i >= 0; i--) begin
        idx = ID_W'((int'(ptr) + i) % N);
        if (req[idx]) begin
          gnt_id    = idx;
          gnt_valid = 1'b1;
        end
      end
      if (gnt_valid) gnt_onehot[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1/8N2 UART transmit line between N_REQ byte streams with packet locking.
//   state | meaning
//   IDLE  | line high, arbitrating on every tick_baud
//   START | start bit (low)
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit(s); the last stop tick is also an arbitration point
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N_REQ        = 4,
  parameter int STOP_BITS    = 1,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_baud,
  uart_tx_arbiter_if.slave         req,
  output logic                     txd,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     locked
);

  localparam int ID_W = id_width(N_REQ);
  localparam int TO_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;
  localparam logic       STOP_INIT = (STOP_BITS == 2);

  logic [1:0]             state;
  logic [UART_DATA_W-1:0] shift;
  logic [2:0]             bit_cnt;
  logic                   stop_cnt;
  logic [ID_W-1:0]        rr_ptr;
  logic [TO_W-1:0]        to_cnt;

  logic [N_REQ-1:0] gnt_onehot;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             ap;
  logic             xfer;
  logic             stall;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req        (req.req_valid),
    .ptr        (rr_ptr),
    .lock       (locked),
    .lock_id    (grant_id),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid)
  );

  assign ap            = tick_baud && (state == ST_IDLE || (state == ST_STOP && !stop_cnt));
  assign xfer          = ap && gnt_valid;
  assign req.req_ready = xfer ? gnt_onehot : '0;
  assign stall         = ap && locked && !req.req_valid[grant_id];
  assign busy          = (state != ST_IDLE);

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      grant_id <= '0;
      locked   <= 1'b0;
      rr_ptr   <= '0;
      to_cnt   <= '0;
    end else if (xfer) begin
      state    <= ST_START;
      txd      <= 1'b0;
      shift    <= req.req_data[gnt_id];
      grant_id <= gnt_id;
      to_cnt   <= '0;
      if (req.req_last[gnt_id]) begin
        locked <= 1'b0;
        rr_ptr <= next_id(gnt_id);
      end else begin
        locked <= 1'b1;
      end
    end else begin
      // The dropped lock only takes effect at the following arbitration point.
      if (stall && LOCK_TIMEOUT != 0) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (to_cnt + TO_W'(1) == TO_W'(LOCK_TIMEOUT)) begin
          locked <= 1'b0;
          rr_ptr <= next_id(grant_id);
        end
      end
      case (state)
        ST_START: if (tick_baud) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
          txd     <= shift[0];
        end
        ST_DATA: if (tick_baud) begin
          if (bit_cnt == 3'd7) begin
            state    <= ST_STOP;
            stop_cnt <= STOP_INIT;
            txd      <= 1'b1;
          end else begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            txd     <= shift[1];
          end
        end
        ST_STOP: if (tick_baud) begin
          if (stop_cnt) stop_cnt <= 1'b0;
          else          state    <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one 8N1 instance with a short lock timeout, one 8N2 instance.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_baud = 1'b0;
  int unsigned div = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic       txd_a, busy_a, lock_a;
  logic [1:0] gid_a;
  logic       txd_b, busy_b, lock_b;
  logic [1:0] gid_b;

  uart_tx_arbiter_if #(.N_REQ(4)) ifa ();
  uart_tx_arbiter_if #(.N_REQ(4)) ifb ();

  uart_tx_arbiter #(.N_REQ(4), .STOP_BITS(1), .LOCK_TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_baud(tick_baud), .req(ifa),
    .txd(txd_a), .busy(busy_a), .grant_id(gid_a), .locked(lock_a)
  );

  uart_tx_arbiter #(.N_REQ(4), .STOP_BITS(2), .LOCK_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_baud(tick_baud), .req(ifb),
    .txd(txd_b), .busy(busy_b), .grant_id(gid_b), .locked(lock_b)
  );

  always #5 clk = ~clk;

  // Baud strobe: one clk high out of every 16.
  always begin
    @(negedge clk);
    tick_baud = (div % 16 == 15);
    div++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [3:0] rdy(input bit b);
    return b ? ifb.req_ready : ifa.req_ready;
  endfunction
  function automatic logic txd_of(input bit b);
    return b ? txd_b : txd_a;
  endfunction
  function automatic logic busy_of(input bit b);
    return b ? busy_b : busy_a;
  endfunction
  function automatic logic [1:0] gid_of(input bit b);
    return b ? gid_b : gid_a;
  endfunction

  // Waits for a ready strobe, expects it on requester k during a tick, and returns
  // the number of earlier ticks that passed without an acceptance. Exits one cycle later.
  task automatic accept(input bit b, input int k, input string tag, output int n_ticks);
    int n;
    n = 0;
    n_ticks = 0;
    #1;
    while (rdy(b) == 4'd0 && n < 800) begin
      if (tick_baud) n_ticks++;
      step();
      n++;
    end
    chk({tag, "_ready"}, rdy(b), 32'd1 << k);
    chk({tag, "_on_tick"}, tick_baud, 1);
    step();
    chk({tag, "_grant_id"}, gid_of(b), k);
  endtask

  // Entered one cycle after the accepting AP; samples txd mid-bit for the whole frame.
  task automatic check_frame(input bit b, input logic [7:0] data, input int nstop, input string tag);
    logic e;
    repeat (7) step();
    for (int j = 0; j < 9 + nstop; j++) begin
      e = (j == 0) ? 1'b0 : (j <= 8) ? data[j-1] : 1'b1;
      chk($sformatf("%s_bit%0d", tag, j), txd_of(b), e);
      if (j == 0) chk({tag, "_busy"}, busy_of(b), 1);
      if (j < 8 + nstop) repeat (16) step();
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    step();
    while (!tick_baud && n < 40) begin
      step();
      n++;
    end
    chk("wait_tick_bound", (n < 40), 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int nt;
    int n;
    int bad;
    ifa.req_valid = '0; ifa.req_data = '0; ifa.req_last = '0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.req_last = '0;
    repeat (3) step();
    chk("rst_txd", txd_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", ifa.req_ready, 0);
    chk("rst_grant_id", gid_a, 0);
    chk("rst_locked", lock_a, 0);
    rst_n = 1'b1;
    step();

    // Single byte, valid rising in a tick cycle.
    n = 0;
    while (!tick_baud && n < 40) begin step(); n++; end
    ifa.req_data[2] = 8'hA5; ifa.req_last[2] = 1'b1; ifa.req_valid[2] = 1'b1;
    accept(0, 2, "single", nt);
    chk("single_no_wait", nt, 0);
    ifa.req_valid[2] = 1'b0;
    check_frame(0, 8'hA5, 1, "single");
    repeat (8) step();
    chk("single_busy_last", busy_a, 1);
    step();
    chk("single_busy_end", busy_a, 0);
    chk("single_txd_idle", txd_a, 1);

    // Fairness from rr_ptr = 0.
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      ifa.req_data[k] = 8'(16 + k); ifa.req_last[k] = 1'b1; ifa.req_valid[k] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      accept(0, k, $sformatf("fair%0d", k), nt);
      if (k > 0) chk($sformatf("fair%0d_gap", k), nt, 0);
      ifa.req_valid[k] = 1'b0;
      check_frame(0, 8'(16 + k), 1, $sformatf("fair%0d", k));
    end
    ifa.req_valid[0] = 1'b1; ifa.req_valid[3] = 1'b1;
    accept(0, 0, "wrap0", nt);
    chk("wrap0_gap", nt, 0);
    ifa.req_valid[0] = 1'b0;
    check_frame(0, 8'h10, 1, "wrap0");
    accept(0, 3, "wrap3", nt);
    ifa.req_valid[3] = 1'b0;
    check_frame(0, 8'h13, 1, "wrap3");
    repeat (9) step();
    chk("fair_idle", busy_a, 0);

    // Packet lock: req1 three bytes while req0 waits.
    pulse_reset();
    ifa.req_data[1] = 8'h21; ifa.req_last[1] = 1'b0; ifa.req_valid[1] = 1'b1;
    accept(0, 1, "lk1", nt);
    chk("lk1_locked", lock_a, 1);
    ifa.req_data[1] = 8'h22;
    ifa.req_data[0] = 8'h0F; ifa.req_last[0] = 1'b1; ifa.req_valid[0] = 1'b1;
    check_frame(0, 8'h21, 1, "lk1");
    accept(0, 1, "lk2", nt);
    chk("lk2_locked", lock_a, 1);
    ifa.req_data[1] = 8'h23; ifa.req_last[1] = 1'b1;
    check_frame(0, 8'h22, 1, "lk2");
    accept(0, 1, "lk3", nt);
    chk("lk3_unlocked", lock_a, 0);
    ifa.req_valid[1] = 1'b0;
    check_frame(0, 8'h23, 1, "lk3");
    accept(0, 0, "lk4", nt);
    chk("lk4_gap", nt, 0);
    ifa.req_valid[0] = 1'b0;
    check_frame(0, 8'h0F, 1, "lk4");
    repeat (9) step();

    // Lock timeout after four stalled APs.
    pulse_reset();
    ifa.req_data[1] = 8'h33; ifa.req_last[1] = 1'b0; ifa.req_valid[1] = 1'b1;
    accept(0, 1, "to1", nt);
    ifa.req_valid[1] = 1'b0;
    ifa.req_data[3] = 8'h3C; ifa.req_last[3] = 1'b1; ifa.req_valid[3] = 1'b1;
    chk("to1_locked", lock_a, 1);
    check_frame(0, 8'h33, 1, "to1");
    for (int i = 1; i <= 4; i++) begin
      wait_tick();
      chk($sformatf("to_ap%0d_ready", i), ifa.req_ready, 0);
      chk($sformatf("to_ap%0d_locked", i), lock_a, 1);
    end
    step();
    chk("to_unlocked", lock_a, 0);
    accept(0, 3, "to3", nt);
    chk("to3_fifth_ap", nt, 0);
    ifa.req_valid[3] = 1'b0;
    check_frame(0, 8'h3C, 1, "to3");
    repeat (9) step();

    // Reset in the middle of data bit 3.
    pulse_reset();
    ifa.req_data[0] = 8'h00; ifa.req_last[0] = 1'b0; ifa.req_valid[0] = 1'b1;
    accept(0, 0, "rm", nt);
    ifa.req_valid[0] = 1'b0;
    repeat (67) step();
    chk("rm_pre_txd", txd_a, 0);
    chk("rm_pre_locked", lock_a, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_txd", txd_a, 1);
    chk("rm_busy", busy_a, 0);
    chk("rm_locked", lock_a, 0);
    ifa.req_data[2] = 8'h5A; ifa.req_last[2] = 1'b1; ifa.req_valid[2] = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    bad = 0;
    n = 0;
    while (!tick_baud && n < 40) begin
      if (ifa.req_ready != 4'd0) bad++;
      step();
      n++;
    end
    chk("rm_early_ready", bad, 0);
    accept(0, 2, "rm_after", nt);
    chk("rm_after_first_tick", nt, 0);
    ifa.req_valid[2] = 1'b0;
    check_frame(0, 8'h5A, 1, "rm_after");
    repeat (9) step();

    // Two stop bits, back-to-back frames.
    ifb.req_data[0] = 8'h00; ifb.req_last[0] = 1'b1; ifb.req_valid[0] = 1'b1;
    ifb.req_data[1] = 8'h00; ifb.req_last[1] = 1'b1; ifb.req_valid[1] = 1'b1;
    accept(1, 0, "s2a", nt);
    ifb.req_valid[0] = 1'b0;
    check_frame(1, 8'h00, 2, "s2a");
    accept(1, 1, "s2b", nt);
    chk("s2b_gap", nt, 0);
    ifb.req_valid[1] = 1'b0;
    check_frame(1, 8'h00, 2, "s2b");
    repeat (25) step();
    chk("s2_idle", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line between `N_REQ` byte-stream requesters. It arbitrates round-robin with packet locking, then serialises the granted byte as an 8N1 (or 8N2) frame. All bit boundaries are paced by the 1X `tick_baud` strobe from the baud generator. It sits between the on-chip message sources (hash-result reporter, status/debug, command echo) and the `txd` pad.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters; ≥2.
- `STOP_BITS`, 1 — stop bits per frame; 1 or 2.
- `LOCK_TIMEOUT`, 16 — arbitration points a locked, non-valid requester may stall before its lock is dropped; 0 = never drop.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `tick_baud` in 1 — one-clk strobe at BAUD rate.
- `req_valid` in N_REQ — per-requester byte valid.
- `req_data` in N_REQ×8 — per-requester byte.
- `req_last` in N_REQ — byte is the final byte of its packet.
- `req_ready` out N_REQ — one-hot acceptance strobe; combinational.
- `txd` out 1 — serial line; registered; idle high.
- `busy` out 1 — a frame is in progress.
- `grant_id` out $clog2(N_REQ) — requester owning the current or last frame.
- `locked` out 1 — a packet lock is held.

## Operation
- Requester rule: once `req_valid[i]` rises, `req_data[i]` and `req_last[i]` stay stable and valid stays high until `req_ready[i]`. Transfer = valid & ready in the same cycle.
- Arbitration point (AP): a cycle with `tick_baud`=1 while in IDLE, or while in STOP when the final stop bit ends. All acceptance happens only at an AP.
- Winner selection:
  - Unlocked: the first valid requester searching upward from `rr_ptr`, modulo N_REQ.
  - Locked: only `grant_id` may win.
- On transfer of requester k:
  - `req_ready[k]`=1 for that single cycle.
  - Shift register ← data; `grant_id` ← k.
  - If `req_last`=0: `locked` ← 1.
  - If `req_last`=1: `locked` ← 0 and `rr_ptr` ← (k+1) mod N_REQ.
- States:
  - IDLE: `txd`=1, `busy`=0. On AP with a winner → START. Otherwise stay.
  - START: `txd`=0. On `tick_baud` → DATA, `bit_cnt`=0.
  - DATA: `txd`=shift[0], LSB first. On `tick_baud` shift right; at `bit_cnt`=7 → STOP.
  - STOP: `txd`=1. On `tick_baud`, if stop bits remain, count down. On the final stop tick (an AP): with a winner → START directly, giving no idle gap; otherwise → IDLE.
- Lock timeout:
  - `to_cnt` increments at each AP where `locked`=1 and `req_valid[grant_id]`=0.
  - `to_cnt` clears on any transfer.
  - On reaching LOCK_TIMEOUT (≠0): `locked` ← 0 and `rr_ptr` ← `grant_id`+1. Other requesters become eligible at the next AP, not at the same one.
- Simultaneous events:
  - A `tick_baud` at the same cycle as a valid rise is a legal AP; the byte is accepted.
  - `req_valid` of a non-winner is ignored; it holds.

## Timing
- Reset values: `txd`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `locked`=0, `rr_ptr`=0, `to_cnt`=0, state=IDLE.
- Reset asserted mid-frame forces `txd`=1 immediately (async); the frame is discarded, not resumed.
- `txd` and `busy` change on the clk after the `tick_baud` (or AP) cycle.
- Each bit lasts exactly one `tick_baud` period.
- Frame length = (10 + STOP_BITS − 1) baud periods.
- Acceptance latency from valid: 0 to one full frame plus one baud period.
- `busy`=1 from the cycle after an accepting AP until the cycle after the final stop tick with no winner.
- Counter widths:
  - `bit_cnt`: 3 bits.
  - stop count: 1 bit.
  - `to_cnt`: $clog2(LOCK_TIMEOUT+1) bits, saturating.

## Structure
- `uart_pkg`: `tx_state_e` {IDLE, START, DATA, STOP}, `UART_DATA_W`=8, plus a helper function for the id width.
- Sub-module `rr_arbiter`:
  - Inputs: `req[N]`, `ptr`, `lock`, `lock_id`.
  - Outputs: `gnt_onehot`, `gnt_id`, `gnt_valid`.
  - Purely combinational; reused by the future RX command dispatcher.
- The top contains the FSM, shift register, counters and lock/timeout logic.

## Test plan
Bench drives `tick_baud` every 16 clks; N_REQ=4.
- Single byte: req2 sends 0xA5, last=1 → `req_ready[2]` one cycle on a tick. `txd` per baud = 0,1,0,1,0,0,1,0,1,1. `busy` is 1 for 160 clks. `grant_id`=2.
- Fairness: all four valid with last=1, `rr_ptr`=0 → grants in order 0,1,2,3. Frames run back-to-back with no idle high between stop and start. `rr_ptr` ends at 0.
- Packet lock: req1 sends 3 bytes with last only on the third, while req0 is valid throughout → order 1,1,1,0. `locked`=1 during bytes 1–2 and 0 after the third.
- Timeout (LOCK_TIMEOUT=4): req1 sends 0x33 with last=0, then drops valid; req3 is valid → req3 is granted at the 5th AP after the stop bit. `locked`=0 before the grant; `grant_id`=3.
- Reset mid-frame: `rst_n` low during data bit 3 → `txd`=1, `busy`=0, `locked`=0 in the same cycle. After release, no `req_ready` before the next `tick_baud`.
- STOP_BITS=2: byte 0x00 → `txd` = 0 for 9 baud periods, then 1 for 2, then the next start bit.
